// File: rtl/podule_irq_pkg.sv
// rtl/podule_irq_pkg.sv - register map and helpers for the podule interrupt controller
package podule_irq_pkg;

   typedef enum logic [2:0] {
      REG_STATUS = 3'd0,
      REG_PEND   = 3'd1,
      REG_IRQ_EN = 3'd2,
      REG_FIQ_EN = 3'd3,
      REG_MODE   = 3'd4,
      REG_POL    = 3'd5,
      REG_VECTOR = 3'd6,
      REG_SET    = 3'd7
   } reg_idx_e;

   localparam logic [7:0] VEC_NONE = 8'hFF;

   function automatic int lanes(input int n);
      return (n + 7) / 8;
   endfunction

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - multi-stage flop synchroniser for asynchronous inputs
module irq_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/podule_irq_ctrl.sv
// rtl/podule_irq_ctrl.sv - parametrised IRQ/FIQ controller on the IOC byte bus
module podule_irq_ctrl
   import podule_irq_pkg::*;
#(
   parameter int N_SRC       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src,
   input  logic             cs,
   input  logic             rd,
   input  logic             wr,
   input  logic [4:0]       addr,
   input  logic [7:0]       din,
   output logic [7:0]       dout,
   output logic             irq,
   output logic             fiq
);

   localparam int L = lanes(N_SRC);

   logic [N_SRC-1:0] src_s, s, edge_det, wbits, wmask, clr, set, vec_req;
   logic [N_SRC-1:0] s_prev_q, pend_q, pend_d, irq_en_q, irq_en_d, fiq_en_q, fiq_en_d;
   logic [N_SRC-1:0] mode_q, mode_d, pol_q, pol_d;
   logic             wr_act, wr_s, wr_prev_q, commit;
   logic             irq_q, fiq_q, irq_d, fiq_d;
   logic [1:0]       lane;
   logic             lane_ok;
   reg_idx_e         reg_idx;
   logic [7:0]       vec;
   logic [31:0]      rd32;
   logic             unused_rd;

   assign unused_rd = rd;

   assign wr_act = cs & wr;

   irq_sync #(.WIDTH(N_SRC), .STAGES(SYNC_STAGES)) u_src_sync (
      .clk_i(clk), .rst_i(rst), .d_i(src), .q_o(src_s)
   );

   irq_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_wr_sync (
      .clk_i(clk), .rst_i(rst), .d_i(wr_act), .q_o(wr_s)
   );

   assign s        = src_s ^ pol_q;
   assign edge_det = s & ~s_prev_q;
   assign commit   = wr_s & ~wr_prev_q;

   assign lane    = addr[1:0];
   assign reg_idx = reg_idx_e'(addr[4:2]);
   assign lane_ok = int'(lane) < L;
   assign wbits   = N_SRC'(32'(din) << {lane, 3'b000});
   assign wmask   = lane_ok ? N_SRC'(32'h0000_00FF << {lane, 3'b000}) : '0;

   always_comb begin
      irq_en_d = irq_en_q;
      fiq_en_d = fiq_en_q;
      mode_d   = mode_q;
      pol_d    = pol_q;
      clr      = '0;
      set      = '0;
      if (commit) begin
         case (reg_idx)
            REG_PEND:   clr      = wbits & wmask;
            REG_IRQ_EN: irq_en_d = (irq_en_q & ~wmask) | (wbits & wmask);
            REG_FIQ_EN: fiq_en_d = (fiq_en_q & ~wmask) | (wbits & wmask);
            REG_MODE:   mode_d   = (mode_q & ~wmask) | (wbits & wmask);
            REG_POL:    pol_d    = (pol_q & ~wmask) | (wbits & wmask);
            REG_SET:    set      = wbits & wmask;
            default:    ;
         endcase
      end
      // Edge bits: a new edge beats a same-cycle clear; level bits just track s.
      pend_d = (mode_q & ((pend_q & ~clr) | edge_det | set)) | (~mode_q & s);
      irq_d  = |(pend_q & irq_en_q & ~fiq_en_q);
      fiq_d  = |(pend_q & fiq_en_q);
   end

   assign vec_req = pend_q & irq_en_q & ~fiq_en_q;

   always_comb begin
      vec = VEC_NONE;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (vec_req[i]) vec = 8'(i);
      end
   end

   always_comb begin
      rd32 = '0;
      case (reg_idx)
         REG_STATUS: rd32 = 32'(s);
         REG_PEND:   rd32 = 32'(pend_q);
         REG_IRQ_EN: rd32 = 32'(irq_en_q);
         REG_FIQ_EN: rd32 = 32'(fiq_en_q);
         REG_MODE:   rd32 = 32'(mode_q);
         REG_POL:    rd32 = 32'(pol_q);
         REG_VECTOR: rd32 = 32'(vec);
         default:    rd32 = '0;
      endcase
   end

   assign dout = lane_ok ? 8'(rd32 >> {lane, 3'b000}) : 8'h00;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_prev_q  <= '0;
         pend_q    <= '0;
         irq_en_q  <= '0;
         fiq_en_q  <= '0;
         mode_q    <= '0;
         pol_q     <= '0;
         wr_prev_q <= 1'b0;
         irq_q     <= 1'b0;
         fiq_q     <= 1'b0;
      end else begin
         s_prev_q  <= s;
         pend_q    <= pend_d;
         irq_en_q  <= irq_en_d;
         fiq_en_q  <= fiq_en_d;
         mode_q    <= mode_d;
         pol_q     <= pol_d;
         wr_prev_q <= wr_s;
         irq_q     <= irq_d;
         fiq_q     <= fiq_d;
      end
   end

   assign irq = irq_q;
   assign fiq = fiq_q;

endmodule

// File: tb/tb_podule_irq_ctrl.sv
// tb/tb_podule_irq_ctrl.sv - directed self-checking bench for podule_irq_ctrl
module tb_podule_irq_ctrl;

   localparam int N = 12;
   localparam logic [2:0] R_STATUS = 3'd0, R_PEND = 3'd1, R_IRQ_EN = 3'd2, R_FIQ_EN = 3'd3;
   localparam logic [2:0] R_MODE = 3'd4, R_POL = 3'd5, R_VECTOR = 3'd6, R_SET = 3'd7;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] src = '0;
   logic         cs = 1'b0, rd = 1'b0, wr = 1'b0;
   logic [4:0]   addr = '0;
   logic [7:0]   din = '0;
   logic [7:0]   dout;
   logic         irq, fiq;
   int           checks = 0;
   int           fails = 0;

   podule_irq_ctrl #(.N_SRC(N), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .src(src), .cs(cs), .rd(rd), .wr(wr),
      .addr(addr), .din(din), .dout(dout), .irq(irq), .fiq(fiq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic bus_write(input logic [2:0] r, input logic [1:0] ln, input logic [7:0] d);
      addr = {r, ln}; din = d; cs = 1'b1; wr = 1'b1;
      repeat (3) @(negedge clk);
      wr = 1'b0; cs = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic read_reg(input logic [2:0] r, input logic [1:0] ln, output logic [7:0] v);
      addr = {r, ln};
      #1;
      v = dout;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got=%b exp=0", irq); end
      checks++; if (fiq !== 1'b0) begin fails++; $display("FAIL reset_fiq got=%b exp=0", fiq); end
      read_reg(R_VECTOR, 2'd0, v);
      checks++; if (v !== 8'hFF) begin fails++; $display("FAIL reset_vector got=%h exp=ff", v); end
      read_reg(R_STATUS, 2'd0, v);
      checks++; if (v !== 8'h00) begin fails++; $display("FAIL reset_status got=%h exp=00", v); end
      for (int r = 0; r < 8; r++) begin
         read_reg(3'(r), 2'd2, v);
         checks++; if (v !== 8'h00) begin fails++; $display("FAIL reset_lane2 reg=%0d got=%h exp=00", r, v); end
      end
      @(negedge clk);
   endtask

   task automatic test_edge();
      logic [7:0] v;
      bus_write(R_MODE, 2'd0, 8'h08);
      bus_write(R_IRQ_EN, 2'd0, 8'h08);
      src[3] = 1'b1;
      repeat (2) @(negedge clk);
      src[3] = 1'b0;
      @(negedge clk);
      read_reg(R_PEND, 2'd0, v);
      checks++; if (v !== 8'h08) begin fails++; $display("FAIL edge_pend got=%h exp=08", v); end
      checks++; if (irq !== 1'b0) begin fails++; $display("FAIL edge_irq_early got=%b exp=0", irq); end
      @(negedge clk);
      checks++; if (irq !== 1'b1) begin fails++; $display("FAIL edge_irq got=%b exp=1", irq); end
      read_reg(R_VECTOR, 2'd0, v);
      checks++; if (v !== 8'h03) begin fails++; $display("FAIL edge_vector got=%h exp=03", v); end
      @(negedge clk);
      bus_write(R_PEND, 2'd0, 8'h08);
      checks++; if (irq !== 1'b0) begin fails++; $display("FAIL edge_clear_irq got=%b exp=0", irq); end
      read_reg(R_PEND, 2'd0, v);
      checks++; if (v !== 8'h00) begin fails++; $display("FAIL edge_clear_pend got=%h exp=00", v); end
      @(negedge clk);
   endtask

   task automatic test_level_fiq();
      logic [7:0] v;
      bus_write(R_POL, 2'd1, 8'h02);
      bus_write(R_FIQ_EN, 2'd1, 8'h02);
      bus_write(R_IRQ_EN, 2'd1, 8'h02);
      checks++; if (fiq !== 1'b1) begin fails++; $display("FAIL level_fiq got=%b exp=1", fiq); end
      checks++; if (irq !== 1'b0) begin fails++; $display("FAIL level_irq_masked got=%b exp=0", irq); end
      read_reg(R_STATUS, 2'd1, v);
      checks++; if (v !== 8'h02) begin fails++; $display("FAIL level_status got=%h exp=02", v); end
      read_reg(R_PEND, 2'd1, v);
      checks++; if (v !== 8'h02) begin fails++; $display("FAIL level_pend got=%h exp=02", v); end
      read_reg(R_VECTOR, 2'd0, v);
      checks++; if (v !== 8'hFF) begin fails++; $display("FAIL level_vector got=%h exp=ff", v); end
      @(negedge clk);
      src[9] = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (fiq !== 1'b1) begin fails++; $display("FAIL level_fiq_hold got=%b exp=1", fiq); end
      @(negedge clk);
      checks++; if (fiq !== 1'b0) begin fails++; $display("FAIL level_fiq_drop got=%b exp=0", fiq); end
      read_reg(R_PEND, 2'd1, v);
      checks++; if (v !== 8'h00) begin fails++; $display("FAIL level_pend_drop got=%h exp=00", v); end
      @(negedge clk);
      bus_write(R_IRQ_EN, 2'd1, 8'h00);
      bus_write(R_FIQ_EN, 2'd1, 8'h00);
      bus_write(R_POL, 2'd1, 8'h00);
      src[9] = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_vector();
      logic [7:0] v;
      bus_write(R_MODE, 2'd0, 8'hAB);
      bus_write(R_IRQ_EN, 2'd0, 8'h22);
      src[1] = 1'b1; src[5] = 1'b1;
      repeat (2) @(negedge clk);
      src[1] = 1'b0; src[5] = 1'b0;
      repeat (3) @(negedge clk);
      read_reg(R_PEND, 2'd0, v);
      checks++; if (v !== 8'h22) begin fails++; $display("FAIL vec_pend got=%h exp=22", v); end
      read_reg(R_VECTOR, 2'd0, v);
      checks++; if (v !== 8'h01) begin fails++; $display("FAIL vec_lowest got=%h exp=01", v); end
      checks++; if (irq !== 1'b1) begin fails++; $display("FAIL vec_irq got=%b exp=1", irq); end
      @(negedge clk);
      bus_write(R_PEND, 2'd0, 8'h02);
      read_reg(R_VECTOR, 2'd0, v);
      checks++; if (v !== 8'h05) begin fails++; $display("FAIL vec_next got=%h exp=05", v); end
      read_reg(R_PEND, 2'd0, v);
      checks++; if (v !== 8'h20) begin fails++; $display("FAIL vec_pend_after got=%h exp=20", v); end
      @(negedge clk);
      bus_write(R_PEND, 2'd0, 8'h20);
      checks++; if (irq !== 1'b0) begin fails++; $display("FAIL vec_irq_clear got=%b exp=0", irq); end
      read_reg(R_VECTOR, 2'd0, v);
      checks++; if (v !== 8'hFF) begin fails++; $display("FAIL vec_none got=%h exp=ff", v); end
      @(negedge clk);
   endtask

   task automatic test_edge_clear_race();
      logic [7:0] v;
      src[0] = 1'b1;
      addr = {R_PEND, 2'd0}; din = 8'h01; cs = 1'b1; wr = 1'b1;
      repeat (3) @(negedge clk);
      wr = 1'b0; cs = 1'b0; src[0] = 1'b0;
      repeat (3) @(negedge clk);
      read_reg(R_PEND, 2'd0, v);
      checks++; if (v !== 8'h01) begin fails++; $display("FAIL race_set_wins got=%h exp=01", v); end
      @(negedge clk);
      bus_write(R_PEND, 2'd0, 8'h01);
      read_reg(R_PEND, 2'd0, v);
      checks++; if (v !== 8'h00) begin fails++; $display("FAIL race_later_clear got=%h exp=00", v); end
      @(negedge clk);
   endtask

   task automatic test_set_and_reset();
      logic [7:0] v;
      bus_write(R_IRQ_EN, 2'd0, 8'h80);
      bus_write(R_SET, 2'd0, 8'h80);
      checks++; if (irq !== 1'b1) begin fails++; $display("FAIL set_irq got=%b exp=1", irq); end
      read_reg(R_VECTOR, 2'd0, v);
      checks++; if (v !== 8'h07) begin fails++; $display("FAIL set_vector got=%h exp=07", v); end
      @(negedge clk);
      bus_write(R_PEND, 2'd0, 8'h80);
      bus_write(R_MODE, 2'd0, 8'h2B);
      bus_write(R_SET, 2'd0, 8'h80);
      read_reg(R_PEND, 2'd0, v);
      checks++; if (v !== 8'h00) begin fails++; $display("FAIL set_level_ignored got=%h exp=00", v); end
      checks++; if (irq !== 1'b0) begin fails++; $display("FAIL set_level_irq got=%b exp=0", irq); end
      @(negedge clk);
      addr = {R_IRQ_EN, 2'd0}; din = 8'h55; cs = 1'b1; wr = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_irq got=%b exp=0", irq); end
      read_reg(R_MODE, 2'd0, v);
      checks++; if (v !== 8'h00) begin fails++; $display("FAIL rst_mode got=%h exp=00", v); end
      read_reg(R_IRQ_EN, 2'd0, v);
      checks++; if (v !== 8'h00) begin fails++; $display("FAIL rst_irq_en got=%h exp=00", v); end
      read_reg(R_VECTOR, 2'd0, v);
      checks++; if (v !== 8'hFF) begin fails++; $display("FAIL rst_vector got=%h exp=ff", v); end
      addr = {R_IRQ_EN, 2'd0};
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      read_reg(R_IRQ_EN, 2'd0, v);
      checks++; if (v !== 8'h00) begin fails++; $display("FAIL rst_commit_early got=%h exp=00", v); end
      @(negedge clk);
      read_reg(R_IRQ_EN, 2'd0, v);
      checks++; if (v !== 8'h55) begin fails++; $display("FAIL rst_commit_once got=%h exp=55", v); end
      din = 8'hAA;
      repeat (4) @(negedge clk);
      read_reg(R_IRQ_EN, 2'd0, v);
      checks++; if (v !== 8'h55) begin fails++; $display("FAIL rst_no_second_commit got=%h exp=55", v); end
      wr = 1'b0; cs = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_edge();
      test_level_fiq();
      test_vector();
      test_edge_clear_race();
      test_set_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/podule_irq_ctrl.md
# podule_irq_ctrl

Parametrised interrupt controller for the podule FPGA, replacing the fixed five-source interrupt block. It synchronises up to 32 asynchronous interrupt sources, latches edges or follows levels per source, applies separate IRQ and FIQ enable masks, and drives the registered host IRQ/FIQ lines. Host access is through the IOC byte bus under the controller's chip select, and includes a priority vector register so the handler finds the lowest pending source in one read.

## Interface
Parameters:
- N_SRC, 8: number of sources, 1..32; registers are L = ceil(N_SRC/8) byte lanes wide, and bits at or above N_SRC read 0 and ignore writes.
- SYNC_STAGES, 2: flop stages on sources and on the bus write strobe, minimum 2.

Ports:
- clk  in  1  FPGA main clock.
- rst  in  1  asynchronous, active-high reset.
- src  in  N_SRC  raw interrupt sources, asynchronous.
- cs  in  1  controller selected (decode && IOC select).
- rd  in  1  read strobe, active-high, asynchronous.
- wr  in  1  write strobe, active-high, asynchronous.
- addr  in  5  A[6:2]: addr[4:2] selects the register, addr[1:0] selects the byte lane.
- din  in  8  write data.
- dout  out  8  read data.
- irq  out  1  host IRQ, active-high, registered.
- fiq  out  1  host FIQ, active-high, registered.

## Operation
Registers (index):
- 0 STATUS (RO): synchronised src after polarity.
- 1 PEND: reads the pending bits. Writing 1 clears an edge-mode bit; writing 0 has no effect.
- 2 IRQ_EN (RW).
- 3 FIQ_EN (RW).
- 4 MODE (RW): 1 = edge, 0 = level.
- 5 POL (RW): 1 = active-low source.
- 6 VECTOR (RO, lane 0 only): lowest index i with PEND[i] & IRQ_EN[i] & ~FIQ_EN[i], or 0xFF if there is none.
- 7 SET (WO): writing 1 sets an edge-mode pending bit (software trigger).
- Reads of unimplemented lanes return 0. Writes to lanes >= L, or to RO registers other than PEND, are ignored.

Per-source behaviour, where s = sync(src[i]) ^ POL[i]:
- Edge mode: PEND[i] sets on a 0->1 transition of s.
- Level mode: PEND[i] = s each cycle. CLEAR and SET writes have no effect.
- Same-cycle edge and CLEAR: set wins.
- Changing MODE from edge to level: PEND follows s from the next cycle.
- Changing POL can itself produce an edge.

Output logic:
- irq_next = |(PEND & IRQ_EN & ~FIQ_EN).
- fiq_next = |(PEND & FIQ_EN).
- FIQ_EN takes precedence over IRQ_EN.

Bus write:
- wr_act = cs & wr is synchronised through SYNC_STAGES flops.
- On its synchronised rising edge, addr and din are sampled and committed in one cycle. The bus holds both stable while nWE is low.
- One commit per strobe.

Bus read:
- dout = mux(addr) of the register state, combinational. rd only qualifies the external buffers and is not used internally.

## Timing
- Reset values: all registers 0, PEND 0, irq = fiq = 0, VECTOR = 0xFF, dout = 0 at addr 0 (STATUS of masked zeros).
- Reset mid-write: the pending commit is discarded. Synchroniser flops reset to 0, so a strobe that is still high after reset commits once.
- src edge -> PEND set: SYNC_STAGES + 1 clk.
- PEND -> irq/fiq: +1 clk.
- Write strobe asserted -> register updated: SYNC_STAGES + 1 clk.
- CLEAR commit -> irq deasserted: +1 clk.
- Minimum src pulse width for edge capture: 1 clk period plus setup. Narrower pulses may be lost.
- Minimum wr low-high separation: SYNC_STAGES + 1 clk.

## Structure
- Package podule_irq_pkg holds:
  - register index constants (REG_STATUS..REG_SET);
  - VEC_NONE = 8'hFF;
  - localparam function lanes(N).
- Sub-module irq_sync (parameter WIDTH, STAGES) is used for both src and wr_act.
- Priority encoder: a for-loop, lowest index wins.

## Test plan
- Reset then idle, N_SRC=12: irq=fiq=0, VECTOR=0xFF, lane 2 of every register reads 0.
- Edge mode src[3] pulse 2 clk, IRQ_EN=0x08: PEND=0x08 after 3 clk, irq=1 one clk later, VECTOR=3. Write PEND lane0=0x08 -> irq=0.
- src[9] level, POL[9]=1, FIQ_EN lane1=0x02, src[9] driven low: fiq=1 and irq=0. Source driven high: fiq=0 after 4 clk.
- src[1] and src[5] both pending and IRQ-enabled: VECTOR=1. Clear bit 1: VECTOR=5.
- Edge on src[0] in the same cycle as the CLEAR commit for bit 0: PEND[0] stays 1.
- SET lane0=0x80 with MODE[7]=1 and IRQ_EN[7]=1: irq=1. Same SET with MODE[7]=0: no effect. Assert rst mid-strobe: everything returns to reset values, and the still-high strobe causes exactly one commit after reset.
